// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter and related RX/TX blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } arb_state_t;

    localparam int UART_DATA_W  = 8;
    localparam int ARB_START_TO = 16;

    // Index width for n items, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid strictly after ptr, wrapping modulo N.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_id
);

    int            idx;
    logic [IW-1:0] sel;

    // Walk from the farthest candidate to the nearest so the nearest valid one overwrites.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        idx        = 0;
        sel        = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            sel = IW'(idx);
            if (valid[sel]) begin
                gnt_onehot      = '0;
                gnt_onehot[sel] = 1'b1;
                gnt_id          = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock feeding one shared UART transmitter, one byte at a time.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = UART_DATA_W,
    parameter int START_TO = ARB_START_TO,
    localparam int IW      = id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    wr_enb,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [IW-1:0]           grant_id,
    output logic                    locked,
    output logic                    err_start
);

    localparam int CW = $clog2(START_TO + 1);

    arb_state_t        state_reg;
    logic [IW-1:0]     rr_ptr_reg;
    logic [CW-1:0]     to_cnt_reg;
    logic [N_REQ-1:0]  elig_valid;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IW-1:0]     pick_id;
    logic [DATA_W-1:0] pick_data;
    logic              pick_last;
    logic              have_winner;

    // While a packet is open only its owner may be granted.
    always_comb begin
        elig_valid = req_valid;
        if (locked) begin
            elig_valid           = '0;
            elig_valid[grant_id] = req_valid[grant_id];
        end
    end

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid      (elig_valid),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id)
    );

    assign have_winner = (state_reg == ST_IDLE) && rst_n && (|pick_onehot);
    assign req_ready   = have_winner ? pick_onehot : '0;
    assign pick_data   = req_data[int'(pick_id)*DATA_W +: DATA_W];
    assign pick_last   = req_last[pick_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= IW'(N_REQ - 1);
            to_cnt_reg <= '0;
            wr_enb     <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            locked     <= 1'b0;
            err_start  <= 1'b0;
        end else begin
            wr_enb    <= 1'b0;
            err_start <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (have_winner) begin
                        tx_data    <= pick_data;
                        grant_id   <= pick_id;
                        rr_ptr_reg <= pick_id;
                        locked     <= !pick_last;
                        wr_enb     <= 1'b1;
                        state_reg  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt_reg <= '0;
                    state_reg  <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        state_reg <= ST_WAIT_DONE;
                    end else if (to_cnt_reg == CW'(START_TO - 1)) begin
                        // Byte is dropped as consumed; lock state from accept time stands.
                        err_start <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small requester and UART transmitter model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            wr_enb;
    logic [DW-1:0]   tx_data;
    logic            tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            locked;
    logic            err_start;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .START_TO(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_enb    (wr_enb),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .locked    (locked),
        .err_start (err_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       last;
        logic [7:0] data;
    } item_t;

    item_t      req_q[$];
    int         wr_cyc_q[$];
    logic [7:0] wr_data_q[$];
    logic       wr_lock_q[$];
    logic [1:0] wr_gid_q[$];
    int         wr_gap_q[$];
    int         acc_cyc_q[$];
    int         acc_id_q[$];
    int         err_cyc_q[$];

    int       cyc = 0;
    int       fall_cyc = 0;
    int       uart_cnt = 0;
    int       viol = 0;
    logic     uart_en = 1'b1;
    logic [N-1:0] pend = '0;
    logic     busy_prev = 1'b0;
    logic     wr_prev = 1'b0;
    int       n_cmp = 0;
    int       n_fail = 0;

    // Requesters, UART model and logging all act around the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    for (int j = 0; j < req_q.size(); j++) begin
                        if (req_q[j].id == i) begin
                            req_q.delete(j);
                            break;
                        end
                    end
                end
            end
            pend = '0;
            if (!rst_n) begin
                uart_cnt = 0;
            end else begin
                if (uart_cnt > 0) uart_cnt--;
                if (wr_enb && uart_en) uart_cnt = 6;
            end
            tx_busy = uart_en && (uart_cnt >= 1) && (uart_cnt <= 5);
            if (busy_prev && !tx_busy) fall_cyc = cyc;
            busy_prev = tx_busy;
            if (wr_enb) begin
                if (wr_prev) viol++;
                wr_cyc_q.push_back(cyc);
                wr_data_q.push_back(tx_data);
                wr_lock_q.push_back(locked);
                wr_gid_q.push_back(grant_id);
                wr_gap_q.push_back(cyc - fall_cyc);
                $display("[%0d] write byte=%02h grant=%0d locked=%0b", cyc, tx_data, grant_id, locked);
            end
            wr_prev = wr_enb;
            if (err_start) begin
                err_cyc_q.push_back(cyc);
                $display("[%0d] start timeout", cyc);
            end
            req_valid = '0;
            req_last  = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = req_q.size() - 1; j >= 0; j--) begin
                    if (req_q[j].id == i) begin
                        req_valid[i]          = 1'b1;
                        req_last[i]           = req_q[j].last;
                        req_data[i*DW +: DW]  = req_q[j].data;
                    end
                end
            end
            #1;
            pend = req_ready;
            if (req_ready != '0) begin
                if (!$onehot(req_ready)) viol++;
                if (wr_enb || tx_busy) viol++;
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        acc_cyc_q.push_back(cyc);
                        acc_id_q.push_back(i);
                        $display("[%0d] accept req%0d", cyc, i);
                    end
                end
            end
        end
    end

    task automatic push(input int id, input logic last, input logic [7:0] data);
        item_t it;
        it.id = id; it.last = last; it.data = data;
        req_q.push_back(it);
    endtask

    task automatic clear_logs();
        wr_cyc_q.delete(); wr_data_q.delete(); wr_lock_q.delete();
        wr_gid_q.delete(); wr_gap_q.delete(); acc_cyc_q.delete();
        acc_id_q.delete(); err_cyc_q.delete();
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int c = 0; c < budget && wr_data_q.size() < n; c++) @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        push(1, 1'b1, 8'h11);
        repeat (3) @(negedge clk);
        #2;
        n_cmp++; if (wr_enb !== 1'b0)    begin n_fail++; $display("FAIL rst_wr_enb got=%0b exp=0", wr_enb); end
        n_cmp++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_tx_data got=%02h exp=00", tx_data); end
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_req_ready got=%h exp=0", req_ready); end
        n_cmp++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
        n_cmp++; if (locked !== 1'b0)    begin n_fail++; $display("FAIL rst_locked got=%0b exp=0", locked); end
        n_cmp++; if (err_start !== 1'b0) begin n_fail++; $display("FAIL rst_err_start got=%0b exp=0", err_start); end
        req_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single_byte();
        clear_logs();
        push(0, 1'b1, 8'hA5);
        wait_wr(1, 40);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 1) begin n_fail++; $display("FAIL single_wr_count got=%0d exp=1", wr_data_q.size()); end
        n_cmp++; if (acc_id_q.size() !== 1)  begin n_fail++; $display("FAIL single_ready_pulses got=%0d exp=1", acc_id_q.size()); end
        if (wr_data_q.size() >= 1 && acc_id_q.size() >= 1) begin
            n_cmp++; if (wr_data_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%02h exp=a5", wr_data_q[0]); end
            n_cmp++; if (acc_id_q[0] !== 0) begin n_fail++; $display("FAIL single_ready_id got=%0d exp=0", acc_id_q[0]); end
            n_cmp++; if (wr_cyc_q[0] - acc_cyc_q[0] !== 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=1", wr_cyc_q[0] - acc_cyc_q[0]); end
        end
        n_cmp++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold got=%02h exp=a5", tx_data); end
        n_cmp++; if (locked !== 1'b0)   begin n_fail++; $display("FAIL single_locked got=%0b exp=0", locked); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp1 [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        logic [7:0] exp3 [3] = '{8'h43, 8'h40, 8'h41};
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) push(i, 1'b1, exp1[i]);
        wait_wr(4, 120);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 4) begin n_fail++; $display("FAIL rr_count got=%0d exp=4", wr_data_q.size()); end
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            n_cmp++; if (wr_data_q[i] !== exp1[i]) begin n_fail++; $display("FAIL rr_order%0d got=%02h exp=%02h", i, wr_data_q[i], exp1[i]); end
        end
        clear_logs();
        push(0, 1'b1, 8'h20);
        push(2, 1'b1, 8'h22);
        wait_wr(2, 60);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 2) begin n_fail++; $display("FAIL rr2_count got=%0d exp=2", wr_data_q.size()); end
        if (wr_data_q.size() >= 2) begin
            n_cmp++; if (wr_data_q[0] !== 8'h20) begin n_fail++; $display("FAIL rr2_first got=%02h exp=20", wr_data_q[0]); end
            n_cmp++; if (wr_data_q[1] !== 8'h22) begin n_fail++; $display("FAIL rr2_second got=%02h exp=22", wr_data_q[1]); end
        end
        // Pointer now at 2: the scan must start at 3, then wrap to 0 and 1.
        clear_logs();
        push(1, 1'b1, 8'h41);
        push(3, 1'b1, 8'h43);
        push(0, 1'b1, 8'h40);
        wait_wr(3, 80);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 3) begin n_fail++; $display("FAIL rr3_count got=%0d exp=3", wr_data_q.size()); end
        for (int i = 0; i < 3 && i < wr_data_q.size(); i++) begin
            n_cmp++; if (wr_data_q[i] !== exp3[i]) begin n_fail++; $display("FAIL rr3_order%0d got=%02h exp=%02h", i, wr_data_q[i], exp3[i]); end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp_d [4] = '{8'h31, 8'h32, 8'h33, 8'h40};
        logic       exp_l [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_g [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        clear_logs();
        push(0, 1'b1, 8'h0F);
        wait_wr(1, 40);
        repeat (12) @(posedge clk);
        clear_logs();
        push(1, 1'b0, 8'h31);
        push(1, 1'b0, 8'h32);
        push(1, 1'b1, 8'h33);
        push(0, 1'b1, 8'h40);
        wait_wr(4, 150);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 4) begin n_fail++; $display("FAIL lock_count got=%0d exp=4", wr_data_q.size()); end
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            n_cmp++; if (wr_data_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL lock_data%0d got=%02h exp=%02h", i, wr_data_q[i], exp_d[i]); end
            n_cmp++; if (wr_lock_q[i] !== exp_l[i]) begin n_fail++; $display("FAIL lock_flag%0d got=%0b exp=%0b", i, wr_lock_q[i], exp_l[i]); end
            n_cmp++; if (wr_gid_q[i] !== exp_g[i])  begin n_fail++; $display("FAIL lock_grant%0d got=%0d exp=%0d", i, wr_gid_q[i], exp_g[i]); end
        end
    endtask

    task automatic test_timeout();
        uart_en = 1'b0;
        clear_logs();
        push(3, 1'b1, 8'h5A);
        for (int c = 0; c < 60 && err_cyc_q.size() < 1; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        n_cmp++; if (err_cyc_q.size() !== 1) begin n_fail++; $display("FAIL to_pulses got=%0d exp=1", err_cyc_q.size()); end
        n_cmp++; if (wr_data_q.size() !== 1) begin n_fail++; $display("FAIL to_wr_count got=%0d exp=1", wr_data_q.size()); end
        if (err_cyc_q.size() >= 1 && wr_cyc_q.size() >= 1) begin
            // ISSUE at c, WAIT_START entered at c+1, pulse START_TO cycles later.
            n_cmp++; if (err_cyc_q[0] - wr_cyc_q[0] !== TO + 1) begin n_fail++; $display("FAIL to_delay got=%0d exp=%0d", err_cyc_q[0] - wr_cyc_q[0], TO + 1); end
        end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL to_locked got=%0b exp=0", locked); end
        uart_en = 1'b1;
        clear_logs();
        push(3, 1'b1, 8'h6B);
        wait_wr(1, 40);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 1) begin n_fail++; $display("FAIL to_next_count got=%0d exp=1", wr_data_q.size()); end
        if (wr_data_q.size() >= 1) begin
            n_cmp++; if (wr_data_q[0] !== 8'h6B) begin n_fail++; $display("FAIL to_next_data got=%02h exp=6b", wr_data_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        push(1, 1'b0, 8'h77);
        for (int c = 0; c < 40 && !tx_busy; c++) @(posedge clk);
        n_cmp++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_seen got=%0b exp=1", tx_busy); end
        push(2, 1'b1, 8'h88);
        @(negedge clk);
        #2;
        n_cmp++; if (locked !== 1'b1)  begin n_fail++; $display("FAIL mid_pre_locked got=%0b exp=1", locked); end
        n_cmp++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_pre_grant got=%0d exp=1", grant_id); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_enb !== 1'b0)    begin n_fail++; $display("FAIL mid_wr_enb got=%0b exp=0", wr_enb); end
        n_cmp++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL mid_tx_data got=%02h exp=00", tx_data); end
        n_cmp++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL mid_grant got=%0d exp=0", grant_id); end
        n_cmp++; if (locked !== 1'b0)    begin n_fail++; $display("FAIL mid_locked got=%0b exp=0", locked); end
        n_cmp++; if (err_start !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%0b exp=0", err_start); end
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL mid_ready got=%h exp=0", req_ready); end
        repeat (2) @(posedge clk);
        clear_logs();
        push(0, 1'b1, 8'h99);
        @(negedge clk);
        rst_n = 1'b1;
        wait_wr(2, 60);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 2) begin n_fail++; $display("FAIL mid_after_count got=%0d exp=2", wr_data_q.size()); end
        if (wr_data_q.size() >= 2) begin
            n_cmp++; if (wr_data_q[0] !== 8'h99) begin n_fail++; $display("FAIL mid_after_first got=%02h exp=99", wr_data_q[0]); end
            n_cmp++; if (wr_data_q[1] !== 8'h88) begin n_fail++; $display("FAIL mid_after_second got=%02h exp=88", wr_data_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        for (int i = 0; i < 4; i++) push(2, 1'b1, 8'hC0 + 8'(i));
        wait_wr(4, 120);
        repeat (12) @(posedge clk);
        n_cmp++; if (wr_data_q.size() !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", wr_data_q.size()); end
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            n_cmp++; if (wr_data_q[i] !== 8'hC0 + 8'(i)) begin n_fail++; $display("FAIL b2b_data%0d got=%02h exp=%02h", i, wr_data_q[i], 8'hC0 + 8'(i)); end
            if (i > 0) begin
                n_cmp++; if (wr_gap_q[i] !== 2) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d exp=2", i, wr_gap_q[i]); end
            end
        end
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL protocol_violations got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (the `wr_enb`/`tx_data` port of `top_uart`) among `N_REQ` byte producers. Arbitration is round-robin, with an optional packet lock so that a multi-byte message goes out contiguously. The block sequences each byte through the transmitter: issue, wait for the transmitter to go busy, wait for it to go idle. It sits between the on-chip producers (command/status/debug sources) and the UART top.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width; must match the UART.
- `START_TO`, 16: cycles allowed for `tx_busy` to rise after `wr_enb`.

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: requester i has a byte.
- `req_data` in `N_REQ*DATA_W`: byte of requester i at slice [i*DATA_W +: DATA_W].
- `req_last` in `N_REQ`: byte is the final byte of its packet.
- `req_ready` out `N_REQ`: one-hot; byte of requester i accepted this cycle.
- `wr_enb` out 1: one-cycle write strobe to the UART transmitter.
- `tx_data` out `DATA_W`: byte presented with `wr_enb`.
- `tx_busy` in 1: UART transmitter is shifting a frame.
- `grant_id` out `$clog2(N_REQ)`: requester owning the current or last transfer.
- `locked` out 1: arbiter is locked to `grant_id` mid-packet.
- `err_start` out 1: one-cycle pulse, `tx_busy` never rose within `START_TO`.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE, not locked: winner = first i with `req_valid[i]`, scanning upward from `rr_ptr+1` (mod `N_REQ`).
- IDLE, locked: only `grant_id` is eligible; other requesters wait however long.
- IDLE with a winner g:
  - `req_ready[g]` = 1, combinationally, in that same cycle; the byte transfers.
  - Byte and `req_last[g]` are latched; `grant_id` <= g; `rr_ptr` <= g.
  - `locked` <= !`req_last[g]`.
  - Next state is ISSUE.
- ISSUE: `wr_enb` = 1 for exactly one cycle, `tx_data` = latched byte; next state is WAIT_START; timeout counter cleared.
- WAIT_START:
  - `tx_busy` = 1 -> WAIT_DONE.
  - Counter reaches `START_TO` -> `err_start` pulse, go to IDLE. The byte counts as consumed; the lock is kept or cleared per `req_last`.
- WAIT_DONE: `tx_busy` = 0 -> IDLE.
- `tx_data` holds the last byte issued until the next ISSUE.
- `req_ready` is 0 in every state other than IDLE, and 0 in IDLE when there is no eligible valid.
- Simultaneous valids: round-robin only; no fixed priority beyond the reset pointer.
- Mid-operation `rst_n` assertion: immediate return to IDLE; lock cleared; the in-flight byte is abandoned; no `wr_enb` is generated.
- `N_REQ` = 1 degenerates to a pass-through sequencer; `grant_id` width is 1.

## Timing
Reset values:
- `wr_enb` 0, `tx_data` 0, `req_ready` 0, `grant_id` 0, `locked` 0, `err_start` 0.
- State IDLE, `rr_ptr` = `N_REQ`-1, so requester 0 wins first.

Latency and throughput:
- Valid accepted in IDLE at cycle k -> `wr_enb` at k+1.
- `tx_busy` falls at cycle m -> IDLE at m+1 -> earliest next `wr_enb` at m+2.
- Timeout: `err_start` fires `START_TO` cycles after the WAIT_START entry cycle.

Requester handshake:
- A requester must hold `req_valid` and its data stable until it sees `req_ready`.
- A requester may drop `req_valid` before it is granted; this has no side effects.

## Structure
- Shared package `uart_pkg`:
  - State enum `arb_state_t`.
  - Default constants `UART_DATA_W` = 8 and `ARB_START_TO` = 16.
  - Helper function `id_w(n)` returning the `$clog2` width with a minimum of 1.
- One sub-module, `rr_pick`: combinational masked round-robin selector taking `valid[N]` and `ptr`, returning `gnt_onehot` and `gnt_id`. It is reused later by the RX demux.
- Top FSM, lock logic, timeout counter and data latch live in `uart_tx_arbiter`.

## Test plan
- Single byte: req0 sends 0xA5 with `req_last`=1 -> `req_ready[0]` for 1 cycle; `wr_enb` next cycle with `tx_data`=0xA5; `top_uart` loopback `rx_data`=0xA5, `rdy`=1.
- Round-robin: req0..req3 all valid with 0x10..0x13, `last`=1 -> UART order 0x10, 0x11, 0x12, 0x13; then req0 and req2 re-valid -> order 0x20 (req0), 0x22 (req2).
- Packet lock: req1 sends 0x31, 0x32, 0x33 (last on 0x33) while req0 is valid throughout -> bytes 0x31, 0x32, 0x33 contiguous; `locked`=1 until 0x33 is accepted; req0's byte follows.
- Timeout: `tx_busy` tied 0 -> `err_start` pulse exactly `START_TO`=16 cycles after WAIT_START entry; FSM in IDLE; next valid is served.
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE -> all outputs return to reset values the same cycle; after release, req0 wins first.
- Back-to-back timing: req2 continuously valid -> `wr_enb` exactly 2 cycles after each `tx_busy` fall; `req_ready` never asserted outside IDLE.
